// File: rtl/sum_ctrl_pkg.sv
// Shared types and output decode for the 1..10 accumulate control unit.
// The decode function is also used by the bench's reference checks.
package sum_ctrl_pkg;

    localparam int MAX_ITER_DEFAULT = 20;
    localparam int CNT_W_DEFAULT    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CHECK = 3'd2,
        ACC   = 3'd3,
        INC   = 3'd4,
        OUT   = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    typedef struct packed {
        logic A_Mux_Sel;
        logic A_En;
        logic Acc_Mux_Sel;
        logic Acc_En;
        logic Out_Buf_En;
    } ctrl_word_t;

    function automatic ctrl_word_t ctrl_decode(input state_t st);
        ctrl_word_t cw;
        cw = '0;
        case (st)
            INIT: begin
                cw.A_En   = 1'b1;
                cw.Acc_En = 1'b1;
            end
            ACC: begin
                cw.Acc_Mux_Sel = 1'b1;
                cw.Acc_En      = 1'b1;
            end
            INC: begin
                cw.A_Mux_Sel = 1'b1;
                cw.A_En      = 1'b1;
            end
            OUT:     cw.Out_Buf_En = 1'b1;
            default: cw = '0;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/sum_ctrl_fsm_if.sv
// Host/datapath-facing signals of the accumulate control unit.
interface sum_ctrl_fsm_if #(parameter int CNT_W = 8);
    logic             start;
    logic             clr;
    logic             ALe10;
    logic             A_Mux_Sel;
    logic             A_En;
    logic             Acc_Mux_Sel;
    logic             Acc_En;
    logic             Out_Buf_En;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        output start, clr, ALe10,
        input  A_Mux_Sel, A_En, Acc_Mux_Sel, Acc_En, Out_Buf_En,
        input  busy, done, err, iter_cnt
    );

    modport slave (
        input  start, clr, ALe10,
        output A_Mux_Sel, A_En, Acc_Mux_Sel, Acc_En, Out_Buf_En,
        output busy, done, err, iter_cnt
    );
endinterface

// File: rtl/sum_ctrl_fsm_iter_counter.sv
// Saturating loop-pass counter with synchronous clear and enable.
module iter_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_r;

    // counter register; holds at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
endmodule

// File: rtl/sum_ctrl_fsm.sv
// Moore control FSM sequencing the 1..10 accumulate datapath, with a watchdog
// that traps a loop still running after MAX_ITER passes.
module sum_ctrl_fsm
    import sum_ctrl_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    sum_ctrl_fsm_if.slave  bus
);
    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] iter_cnt_s;
    ctrl_word_t       ctrl_r;
    ctrl_word_t       ctrl_next_s;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             busy_next_s;
    logic             done_next_s;
    logic             err_next_s;

    iter_counter #(.CNT_W(CNT_W)) u_iter_counter (
        .clk (clk),
        .rst (rst),
        .clr (state_r == INIT),
        .en  (state_r == INC),
        .cnt (iter_cnt_s)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state logic; outputs are decoded from the next state so they land registered
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:  next_state_s = bus.start ? INIT : IDLE;
            INIT:  next_state_s = CHECK;
            CHECK: begin
                if (!bus.ALe10) begin
                    next_state_s = OUT;
                end else if (iter_cnt_s < CNT_W'(MAX_ITER)) begin
                    next_state_s = ACC;
                end else begin
                    next_state_s = ERR;
                end
            end
            ACC:     next_state_s = INC;
            INC:     next_state_s = CHECK;
            OUT:     next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            ERR:     next_state_s = bus.clr ? IDLE : ERR;
            default: next_state_s = IDLE;
        endcase
        ctrl_next_s = ctrl_decode(next_state_s);
        busy_next_s = !(next_state_s inside {IDLE, DONE, ERR});
        done_next_s = (next_state_s == DONE);
        err_next_s  = (next_state_s == ERR);
    end

    // output registers, always equal to the decode of state_r
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            ctrl_r <= ctrl_next_s;
            busy_r <= busy_next_s;
            done_r <= done_next_s;
            err_r  <= err_next_s;
        end
    end

    assign bus.A_Mux_Sel   = ctrl_r.A_Mux_Sel;
    assign bus.A_En        = ctrl_r.A_En;
    assign bus.Acc_Mux_Sel = ctrl_r.Acc_Mux_Sel;
    assign bus.Acc_En      = ctrl_r.Acc_En;
    assign bus.Out_Buf_En  = ctrl_r.Out_Buf_En;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.err         = err_r;
    assign bus.iter_cnt    = iter_cnt_s;
endmodule
